// File: rtl/pcs_rx_ctrl_pkg.sv
// Shared types and defaults for the PCS RX link bring-up sequencer.
// State encoding is visible on state_o, so the values below are fixed.
package pcs_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_WAIT_SD  = 3'd1,
    ST_WAIT_BS  = 3'd2,
    ST_WAIT_AM  = 3'd3,
    ST_WAIT_DSK = 3'd4,
    ST_UP       = 3'd5,
    ST_RETRY    = 3'd6,
    ST_ILLEGAL  = 3'd7
  } link_state_e;

  localparam int DEF_RST_CYCLES  = 16;
  localparam int DEF_BS_TIMEOUT  = 8192;
  localparam int DEF_AM_TIMEOUT  = 65536;
  localparam int DEF_DSK_TIMEOUT = 4096;
  localparam int DEF_TMO_W       = 17;
  localparam int RETRY_W         = 8;

  // Lanes stay in reset until SerDes lock is seen, and are reset again on a retry.
  function automatic logic holds_lane_rst(input link_state_e s);
    return (s == ST_RST) || (s == ST_WAIT_SD) || (s == ST_RETRY);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static lock flags from foreign clock domains.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// Link bring-up/recovery sequencer for the multi-lane PCS RX datapath.
// Walks SerDes -> block sync -> AM lock -> deskew and restarts on lock loss or stage timeout.
module pcs_rx_link_ctrl
  import pcs_rx_ctrl_pkg::*;
#(
  parameter int LANE_N      = 4,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int BS_TIMEOUT  = DEF_BS_TIMEOUT,
  parameter int AM_TIMEOUT  = DEF_AM_TIMEOUT,
  parameter int DSK_TIMEOUT = DEF_DSK_TIMEOUT,
  parameter int TMO_W       = DEF_TMO_W
) (
  input  logic                pcs_clk,
  input  logic                nreset,
  input  logic [LANE_N-1:0]   serdes_lock_i,
  input  logic [LANE_N-1:0]   bs_lock_v_i,
  input  logic [LANE_N-1:0]   am_lock_v_i,
  input  logic                deskew_v_i,
  output logic [LANE_N-1:0]   lane_rst_o,
  output logic                realign_o,
  output logic                link_up_o,
  output logic [2:0]          state_o,
  output logic [RETRY_W-1:0]  retry_cnt_o
);

  localparam logic [TMO_W-1:0]   RST_LAST  = TMO_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]   BS_LAST   = TMO_W'(BS_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   AM_LAST   = TMO_W'(AM_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   DSK_LAST  = TMO_W'(DSK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE   = TMO_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  logic [LANE_N-1:0] serdes_sync;
  logic [LANE_N-1:0] bs_sync;

  sync_2ff #(.W(LANE_N)) u_sync_serdes (
    .clk   (pcs_clk),
    .rst_n (nreset),
    .d_i   (serdes_lock_i),
    .q_o   (serdes_sync)
  );

  sync_2ff #(.W(LANE_N)) u_sync_bs (
    .clk   (pcs_clk),
    .rst_n (nreset),
    .d_i   (bs_lock_v_i),
    .q_o   (bs_sync)
  );

  link_state_e          state_q,    state_d;
  logic [TMO_W-1:0]     tmo_q,      tmo_d;
  logic [RETRY_W-1:0]   retry_q,    retry_d;
  logic [LANE_N-1:0]    lane_rst_q, lane_rst_d;
  logic                 realign_q,  realign_d;
  logic                 link_up_q,  link_up_d;

  logic sd_ok, bs_ok, am_ok;

  always_comb begin
    sd_ok     = &serdes_sync;
    bs_ok     = &bs_sync;
    am_ok     = &am_lock_v_i;
    state_d   = state_q;
    realign_d = 1'b0;

    // Lock-loss checks come first in each state so that they beat stage progress.
    case (state_q)
      ST_RST: begin
        if (tmo_q == RST_LAST) state_d = ST_WAIT_SD;
      end
      ST_WAIT_SD: begin
        if (sd_ok) state_d = ST_WAIT_BS;
      end
      ST_WAIT_BS: begin
        if (!sd_ok) begin
          state_d = ST_RETRY;
        end else if (bs_ok) begin
          state_d   = ST_WAIT_AM;
          realign_d = 1'b1;
        end else if (tmo_q == BS_LAST) begin
          state_d = ST_RETRY;
        end
      end
      ST_WAIT_AM: begin
        if (!sd_ok || !bs_ok)        state_d = ST_RETRY;
        else if (am_ok)              state_d = ST_WAIT_DSK;
        else if (tmo_q == AM_LAST)   state_d = ST_RETRY;
      end
      ST_WAIT_DSK: begin
        if (!sd_ok || !bs_ok || !am_ok) state_d = ST_RETRY;
        else if (deskew_v_i)            state_d = ST_UP;
        else if (tmo_q == DSK_LAST)     state_d = ST_RETRY;
      end
      ST_UP: begin
        if (!sd_ok || !bs_ok || !am_ok) begin
          state_d = ST_RETRY;
        end else if (!deskew_v_i) begin
          // Deskew slip only needs a realign, not a full lane reset.
          state_d   = ST_WAIT_AM;
          realign_d = 1'b1;
        end
      end
      ST_RETRY: begin
        state_d = ST_RST;
      end
      default: begin
        state_d = ST_RETRY;
      end
    endcase

    if (state_d != state_q)  tmo_d = '0;
    else if (&tmo_q)         tmo_d = tmo_q;
    else                     tmo_d = tmo_q + TMO_ONE;

    retry_d = retry_q;
    if ((state_d == ST_RETRY) && (state_q != ST_RETRY) && !(&retry_q))
      retry_d = retry_q + RETRY_ONE;

    lane_rst_d = {LANE_N{holds_lane_rst(state_d)}};
    link_up_d  = (state_d == ST_UP);
  end

  always_ff @(posedge pcs_clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_RST;
      tmo_q      <= '0;
      retry_q    <= '0;
      lane_rst_q <= '1;
      realign_q  <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      lane_rst_q <= lane_rst_d;
      realign_q  <= realign_d;
      link_up_q  <= link_up_d;
    end
  end

  assign lane_rst_o  = lane_rst_q;
  assign realign_o   = realign_q;
  assign link_up_o   = link_up_q;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule
